// File: rtl/johnson_phase_mon_if.sv
// Bus between an upstream Johnson counter and the phase monitor.
// The master drives the code and controls; the slave returns decoded phase and status.
interface johnson_phase_mon_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  localparam int IW = $clog2(2 * N);

  logic           en;
  logic           clr;
  logic [N-1:0]   count;
  logic [2*N-1:0] phase;
  logic [IW-1:0]  phase_idx;
  logic           locked;
  logic           wrap;
  logic [CW-1:0]  cycles;
  logic           step_err;
  logic           illegal;

  modport master (
    output en, clr, count,
    input  phase, phase_idx, locked, wrap, cycles, step_err, illegal
  );

  modport slave (
    input  en, clr, count,
    output phase, phase_idx, locked, wrap, cycles, step_err, illegal
  );
endinterface

// File: rtl/johnson_phase_mon.sv
// Monitors an N-bit Johnson code: decodes it to a one-hot phase and index, checks
// that it advances by exactly one phase per enabled sample, and reports lock/wrap/errors.
module johnson_phase_mon #(
  parameter int N      = 4,
  parameter int LOCK_N = 2,
  parameter int CW     = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  johnson_phase_mon_if.slave bus
);
  localparam int P  = 2 * N;
  localparam int IW = $clog2(P);
  localparam int GW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  state_t        r_state;
  logic [N-1:0]  r_sq;
  logic          r_sv;
  logic [IW-1:0] r_prev;
  logic [GW-1:0] r_good;
  logic [P-1:0]  r_phase;
  logic [IW-1:0] r_idx;
  logic          r_locked;
  logic          r_wrap;
  logic [CW-1:0] r_cycles;
  logic          r_step_err;
  logic          r_illegal;

  int            w_trans;
  int            w_ones;
  int            w_idxInt;
  logic          w_legal;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_nextExp;
  logic          w_stepOk;
  logic          w_lockNext;
  logic          w_wrapHit;
  logic          w_stepErr;
  logic [P-1:0]  w_phase;

  // A legal code has at most one 0/1 boundary; bit 0 tells the rising half from the falling half.
  always_comb begin
    w_trans  = 0;
    w_ones   = 0;
    w_idxInt = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (r_sq[i] != r_sq[i+1]) w_trans = w_trans + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (r_sq[i]) w_ones = w_ones + 1;
    end
    if (r_sq[0])
      w_idxInt = w_ones;
    else if (w_ones != 0)
      w_idxInt = P - w_ones;
    w_legal    = (w_trans <= 1);
    w_idx      = IW'(w_idxInt);
    w_nextExp  = (r_prev == IW'(P - 1)) ? '0 : r_prev + IW'(1);
    w_stepOk   = (w_idx == w_nextExp);
    w_lockNext = r_sv && w_legal && w_stepOk &&
                 ((r_state == LOCKED) || ((r_state == ACQ) && (r_good == GW'(LOCK_N - 1))));
    w_wrapHit  = r_sv && w_legal && w_stepOk && (r_state == LOCKED) && (r_prev == IW'(P - 1));
    w_stepErr  = r_sv && w_legal && !w_stepOk && (r_state == LOCKED);
    w_phase    = '0;
    w_phase[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= HUNT;
      r_sq       <= '0;
      r_sv       <= 1'b0;
      r_prev     <= '0;
      r_good     <= '0;
      r_phase    <= '0;
      r_idx      <= '0;
      r_locked   <= 1'b0;
      r_wrap     <= 1'b0;
      r_cycles   <= '0;
      r_step_err <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_sq       <= bus.count;
      r_sv       <= bus.en;
      r_locked   <= w_lockNext;
      r_phase    <= w_lockNext ? w_phase : '0;
      r_idx      <= w_lockNext ? w_idx : '0;
      r_wrap     <= w_wrapHit;
      r_step_err <= w_stepErr;

      if (!r_sv) begin
        r_state <= HUNT;
      end else begin
        r_prev <= w_idx;
        case (r_state)
          HUNT: begin
            if (w_legal) begin
              r_good  <= '0;
              r_state <= ACQ;
            end
          end
          ACQ: begin
            if (!w_legal) begin
              r_state <= HUNT;
            end else if (w_stepOk) begin
              r_good <= r_good + GW'(1);
              if (r_good == GW'(LOCK_N - 1)) r_state <= LOCKED;
            end else begin
              r_good <= '0;
            end
          end
          LOCKED: begin
            if (!w_legal) begin
              r_state <= HUNT;
            end else if (!w_stepOk) begin
              r_good  <= '0;
              r_state <= ACQ;
            end
          end
          default: r_state <= HUNT;
        endcase
      end

      // Clear beats a same-cycle wrap, but a freshly seen illegal code beats clear.
      if (bus.clr)
        r_cycles <= '0;
      else if (w_wrapHit && (r_cycles != {CW{1'b1}}))
        r_cycles <= r_cycles + CW'(1);

      if (r_sv && !w_legal)
        r_illegal <= 1'b1;
      else if (bus.clr)
        r_illegal <= 1'b0;
    end
  end

  assign bus.phase     = r_phase;
  assign bus.phase_idx = r_idx;
  assign bus.locked    = r_locked;
  assign bus.wrap      = r_wrap;
  assign bus.cycles    = r_cycles;
  assign bus.step_err  = r_step_err;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_johnson_phase_mon.sv
// Bench for johnson_phase_mon: directed scenarios plus random code streams, every cycle
// compared against a streak-based model of the phase tracker.
module tb_johnson_phase_mon;
  localparam int N      = 4;
  localparam int LOCK_N = 2;
  localparam int CW     = 2;
  localparam int P      = 2 * N;
  localparam logic [N-1:0] BADCODE = 4'b0101;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  int errCount   = 0;
  int checkCount = 0;
  bit checking   = 1'b0;
  int k          = 0;
  int r          = 0;

  // Model state: the sampled input, the running chain of correct steps and the sticky counters.
  logic [N-1:0] mSq      = '0;
  bit           mSv      = 1'b0;
  bit           mHave    = 1'b0;
  int           mPrev    = 0;
  int           mStreak  = 0;
  bit           mIll     = 1'b0;
  int           mCyc     = 0;
  int           mIdx     = 0;
  bit           mWasLock = 1'b0;
  bit           mGood    = 1'b0;
  bit           mWrapHit = 1'b0;
  bit           mIllNow  = 1'b0;
  logic [P-1:0] ePhase   = '0;
  int           eIdx     = 0;
  bit           eLocked  = 1'b0;
  bit           eWrap    = 1'b0;
  bit           eStep    = 1'b0;

  johnson_phase_mon_if #(.N(N), .CW(CW)) bus ();

  johnson_phase_mon #(.N(N), .LOCK_N(LOCK_N), .CW(CW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] johnsonCode(input int idx);
    logic [N-1:0] c;
    c = '0;
    for (int b = 0; b < N; b++) begin
      if (idx <= N) begin
        if (b < idx) c[b] = 1'b1;
      end else begin
        if (b >= idx - N) c[b] = 1'b1;
      end
    end
    return c;
  endfunction

  function automatic int codeIndex(input logic [N-1:0] c);
    for (int i = 0; i < P; i++) begin
      if (johnsonCode(i) == c) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit c, input logic [N-1:0] code);
    @(posedge clk);
    #3;
    bus.en    = e;
    bus.clr   = c;
    bus.count = code;
  endtask

  task automatic advance();
    applyStimulus(1'b1, 1'b0, johnsonCode(k));
    k = (k + 1) % P;
  endtask

  // Locked means the current chain of legal enabled samples ends in at least LOCK_N correct steps.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mSq = '0; mSv = 1'b0; mHave = 1'b0; mPrev = 0; mStreak = 0; mIll = 1'b0; mCyc = 0;
      ePhase = '0; eIdx = 0; eLocked = 1'b0; eWrap = 1'b0; eStep = 1'b0;
    end else begin
      ePhase = '0; eIdx = 0; eLocked = 1'b0; eWrap = 1'b0; eStep = 1'b0;
      mWrapHit = 1'b0;
      mIllNow  = 1'b0;
      if (mSv) begin
        mIdx = codeIndex(mSq);
        if (mIdx < 0) begin
          mIllNow = 1'b1;
          mHave   = 1'b0;
          mStreak = 0;
        end else begin
          mWasLock = mHave && (mStreak >= LOCK_N);
          mGood    = mHave && (mIdx == (mPrev + 1) % P);
          if (mGood) mStreak++;
          else begin
            eStep   = mWasLock;
            mStreak = 0;
          end
          mWrapHit = mWasLock && mGood && (mPrev == P - 1);
          eWrap    = mWrapHit;
          mHave    = 1'b1;
          mPrev    = mIdx;
          if (mStreak >= LOCK_N) begin
            eLocked      = 1'b1;
            ePhase[mIdx] = 1'b1;
            eIdx         = mIdx;
          end
        end
      end else begin
        mHave   = 1'b0;
        mStreak = 0;
      end
      if (bus.clr) mCyc = 0;
      else if (mWrapHit && mCyc < (1 << CW) - 1) mCyc++;
      if (mIllNow) mIll = 1'b1;
      else if (bus.clr) mIll = 1'b0;
      mSq = bus.count;
      mSv = bus.en;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("phase",     int'(bus.phase),     int'(ePhase));
      checkOutput("phase_idx", int'(bus.phase_idx), eIdx);
      checkOutput("locked",    int'(bus.locked),    int'(eLocked));
      checkOutput("wrap",      int'(bus.wrap),      int'(eWrap));
      checkOutput("cycles",    int'(bus.cycles),    mCyc);
      checkOutput("step_err",  int'(bus.step_err),  int'(eStep));
      checkOutput("illegal",   int'(bus.illegal),   int'(mIll));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.en    = 1'b0;
    bus.clr   = 1'b0;
    bus.count = '0;
    checking  = 1'b1;
    #1;
    checkOutput("reset_locked",  int'(bus.locked), 0);
    checkOutput("reset_phase",   int'(bus.phase),  0);
    checkOutput("reset_cycles",  int'(bus.cycles), 0);
    checkOutput("reset_illegal", int'(bus.illegal), 0);
    #11 arst_n = 1'b1;

    // Free-running counter from reset; outputs after call j reflect sample j-2.
    for (int j = 0; j < 44; j++) begin
      advance();
      if (j == 3) begin
        #1 checkOutput("t1_locked_s1", int'(bus.locked), 0);
      end
      if (j == 4) begin
        #1;
        checkOutput("t1_locked_s2", int'(bus.locked), 1);
        checkOutput("t1_phase_s2",  int'(bus.phase), 8'h04);
        checkOutput("t1_idx_s2",    int'(bus.phase_idx), 2);
      end
      if (j == 10) begin
        #1;
        checkOutput("t1_wrap1",   int'(bus.wrap), 1);
        checkOutput("t1_cycles1", int'(bus.cycles), 1);
        checkOutput("t1_phase0",  int'(bus.phase), 8'h01);
      end
      if (j == 11) begin
        #1 checkOutput("t1_wrap_pulse", int'(bus.wrap), 0);
      end
      if (j == 26 || j == 34 || j == 42) begin
        #1 checkOutput("t4_cycles_sat", int'(bus.cycles), 3);
      end
    end

    // Clear landing on the wrap edge.
    while (k != 0) advance();
    advance();
    applyStimulus(1'b1, 1'b1, johnsonCode(k));
    k = (k + 1) % P;
    advance();
    #1;
    checkOutput("t4_clr_wrap_cycles", int'(bus.cycles), 0);
    checkOutput("t4_clr_wrap_pulse",  int'(bus.wrap), 1);

    // Illegal code while locked, relock, then clear the sticky flag.
    repeat (3) advance();
    applyStimulus(1'b1, 1'b0, BADCODE);
    k = (k + 1) % P;
    advance();
    advance();
    #1;
    checkOutput("t2_illegal", int'(bus.illegal), 1);
    checkOutput("t2_unlock",  int'(bus.locked), 0);
    checkOutput("t2_phase0",  int'(bus.phase), 0);
    repeat (4) advance();
    applyStimulus(1'b1, 1'b1, johnsonCode(k));
    k = (k + 1) % P;
    advance();
    #1;
    checkOutput("t2_clr_illegal", int'(bus.illegal), 0);
    checkOutput("t2_relocked",    int'(bus.locked), 1);

    // Skip 0011 -> 1111 while locked.
    repeat (4) advance();
    while (k != 2) advance();
    advance();
    k = 4;
    advance();
    advance();
    advance();
    #1;
    checkOutput("t3_step_err", int'(bus.step_err), 1);
    checkOutput("t3_unlock",   int'(bus.locked), 0);
    checkOutput("t3_illegal",  int'(bus.illegal), 0);
    advance();
    #1;
    checkOutput("t3_step_pulse", int'(bus.step_err), 0);
    checkOutput("t3_acq",        int'(bus.locked), 0);
    advance();
    #1;
    checkOutput("t3_relock",     int'(bus.locked), 1);
    checkOutput("t3_relock_idx", int'(bus.phase_idx), 6);

    // Enable dropped for three cycles.
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, johnsonCode(k));
      k = (k + 1) % P;
    end
    #1;
    checkOutput("t6_unlock", int'(bus.locked), 0);
    checkOutput("t6_phase0", int'(bus.phase), 0);
    repeat (6) advance();
    #1 checkOutput("t6_relock", int'(bus.locked), 1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #7 arst_n = 1'b0;
    #1;
    checkOutput("t5_locked",  int'(bus.locked), 0);
    checkOutput("t5_phase",   int'(bus.phase), 0);
    checkOutput("t5_idx",     int'(bus.phase_idx), 0);
    checkOutput("t5_cycles",  int'(bus.cycles), 0);
    checkOutput("t5_illegal", int'(bus.illegal), 0);
    @(posedge clk);
    #7 arst_n = 1'b1;
    repeat (6) advance();
    #1 checkOutput("t5_relock", int'(bus.locked), 1);

    // Random mix of clean steps, stalls, skips, junk codes, enable drops and clears.
    for (int j = 0; j < 300; j++) begin
      r = $urandom_range(0, 19);
      if (r < 15) begin
        applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0, johnsonCode(k));
        k = (k + 1) % P;
      end else if (r == 15) begin
        applyStimulus(1'b1, 1'b0, johnsonCode((k + P - 1) % P));
      end else if (r == 16) begin
        k = (k + 1) % P;
        applyStimulus(1'b1, 1'b0, johnsonCode(k));
        k = (k + 1) % P;
      end else begin
        applyStimulus(1'b1, $urandom_range(0, 9) == 0, N'($urandom_range(0, (1 << N) - 1)));
      end
    end
    repeat (12) advance();
    #1 checkOutput("final_locked", int'(bus.locked), 1);

    @(posedge clk);
    #3 checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
